// File: rtl/nonce_scheduler.sv
// Work sequencer: latches the host header, hands disjoint nonce batches to hash
// cores round-robin, and funnels their found-nonce reports onto one result port.
module nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int BATCH_LOG2 = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_work,
  input  logic [639:0]              work_data,
  output logic [607:0]              core_header,
  output logic                      core_abort,
  input  logic [NUM_CORES-1:0]      core_req,
  output logic [NUM_CORES-1:0]      core_grant,
  output logic [31:0]               core_base,
  input  logic [NUM_CORES-1:0]      core_found,
  input  logic [32*NUM_CORES-1:0]   core_nonce,
  output logic [NUM_CORES-1:0]      core_found_ack,
  output logic                      new_result,
  output logic [31:0]               result_data,
  output logic                      exhausted,
  output logic                      busy
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [32:0] BATCH = 33'd1 << BATCH_LOG2;
  localparam logic [31:0] STEP  = BATCH[31:0];
  localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, EXHAUSTED} state_t;

  state_t          state, state_next;
  logic [31:0]     next_nonce;
  logic [32:0]     issued, issued_sum;
  logic [PW-1:0]   grant_ptr, found_ptr;
  logic [PW:0]     gnt_pick, fnd_pick;
  logic [PW-1:0]   gnt_idx, fnd_idx;
  logic            grant_fire, found_fire, stale;

  // Returns {hit, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NUM_CORES-1:0] vec,
                                          input logic [PW-1:0] ptr);
    logic [PW:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_CORES);
      if (vec[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    return PW'((int'(idx) + 1) % NUM_CORES);
  endfunction

  always_comb begin
    gnt_pick   = rr_pick(core_req & ~core_grant, grant_ptr);
    fnd_pick   = rr_pick(core_found & ~core_found_ack, found_ptr);
    gnt_idx    = gnt_pick[PW-1:0];
    fnd_idx    = fnd_pick[PW-1:0];
    issued_sum = issued + BATCH;
    // A restart (or its abort cycle) turns any pending report into a stale one.
    stale      = new_work || core_abort;
    grant_fire = (state == RUN) && !new_work && !core_abort && gnt_pick[PW];
    found_fire = (state != IDLE) && fnd_pick[PW];
  end

  always_comb begin
    state_next = state;
    if (new_work)
      state_next = RUN;
    else if (grant_fire && issued_sum[32])
      state_next = EXHAUSTED;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      core_header    <= '0;
      core_abort     <= 1'b0;
      core_grant     <= '0;
      core_base      <= '0;
      core_found_ack <= '0;
      new_result     <= 1'b0;
      result_data    <= '0;
      exhausted      <= 1'b0;
      next_nonce     <= '0;
      issued         <= '0;
      grant_ptr      <= '0;
      found_ptr      <= '0;
    end else begin
      core_abort     <= 1'b0;
      core_grant     <= '0;
      core_found_ack <= '0;
      new_result     <= 1'b0;

      if (new_work) begin
        core_header <= work_data[639:32];
        next_nonce  <= work_data[31:0];
        issued      <= '0;
        core_abort  <= 1'b1;
        exhausted   <= 1'b0;
      end else if (grant_fire) begin
        core_grant <= ONE << gnt_idx;
        core_base  <= next_nonce;
        next_nonce <= next_nonce + STEP;
        issued     <= issued_sum;
        grant_ptr  <= ptr_after(gnt_idx);
        if (issued_sum[32]) exhausted <= 1'b1;
      end

      if (found_fire) begin
        core_found_ack <= ONE << fnd_idx;
        found_ptr      <= ptr_after(fnd_idx);
        if (!stale) begin
          new_result  <= 1'b1;
          result_data <= core_nonce[32*int'(fnd_idx) +: 32];
        end
      end
    end
  end

endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Sequencer between the host work interface and NUM_CORES hash cores.
- Latches each new 640-bit work header, broadcasts the 608-bit nonce-free prefix, and hands out disjoint nonce batches to requesting cores in round-robin order.
- Arbitrates the cores' found-nonce reports onto a single result port.
- Detects exhaustion of the 2^32 nonce space.

Parameters:
- NUM_CORES, 4, number of hash cores served (2..16).
- BATCH_LOG2, 20, log2 of nonces per grant; batch size = 2^BATCH_LOG2 (0..31).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- new_work  in  1  single-cycle pulse; work_data valid
- work_data  in  640  [639:32] header prefix, [31:0] starting nonce
- core_header  out  608  latched header prefix, broadcast to all cores
- core_abort  out  1  one-cycle pulse; cores drop current batch and clear found
- core_req  in  NUM_CORES  per-core batch request, level
- core_grant  out  NUM_CORES  one-hot, one-cycle grant pulse
- core_base  out  32  first nonce of granted batch; valid while core_grant != 0
- core_found  in  NUM_CORES  per-core result pending, held until acked
- core_nonce  in  32*NUM_CORES  core i nonce at [32*i+31:32*i]
- core_found_ack  out  NUM_CORES  one-hot, one-cycle ack
- new_result  out  1  one-cycle pulse; result_data valid
- result_data  out  32  reported nonce
- exhausted  out  1  all 2^32 nonces of current work issued
- busy  out  1  state == RUN

Behaviour:
Reset (rst=1 at a clock edge):
- state=IDLE; all outputs 0, including core_header and result_data.
- next_nonce=0, issued=0, both round-robin pointers=0.
- rst overrides new_work in the same cycle.

States: IDLE, RUN, EXHAUSTED. In any state, new_work=1 causes, on that edge:
- core_header <= work_data[639:32]; next_nonce <= work_data[31:0]; issued (33-bit) <= 0.
- core_abort <= 1 for exactly the following cycle; exhausted <= 0; state <= RUN.
- No grant and no result in the new_work cycle or the abort cycle.

Grant path (RUN only):
- Requests are sampled at edge t; grant is registered and visible in cycle t+1 (latency 1). At most one grant per cycle.
- Winner = first asserted core_req[i] searching from grant_ptr upward, modulo NUM_CORES. Then grant_ptr <= winner+1 mod NUM_CORES.
- On grant: core_base <= next_nonce; next_nonce <= next_nonce + 2^BATCH_LOG2 (mod 2^32, wraps silently); issued <= issued + 2^BATCH_LOG2.
- core_req[i] is ignored while core_grant[i]=1. Cores deassert req after seeing grant, which prevents double grants.
- When the updated issued equals 2^32: state <= EXHAUSTED, exhausted <= 1 in the same cycle as the final grant. No further grants until new_work.
- With start nonce s, batches cover s, s+B, ... with wrap. The nonce space is exhausted after exactly 2^(32-BATCH_LOG2) grants.
- IDLE and EXHAUSTED: core_grant stays 0 regardless of core_req.

Result path (RUN and EXHAUSTED):
- Independent round-robin over core_found using found_ptr, same search rule.
- Winner w: result_data <= core_nonce[w]; new_result <= 1; core_found_ack[w] <= 1, all for one cycle (registered, latency 1). found_ptr <= w+1 mod NUM_CORES.
- core_found[i] is ignored while core_found_ack[i]=1.
- Stale results: core_found asserted during the new_work cycle or the abort cycle is acked (round-robin, one per cycle) with new_result=0 and result_data unchanged.
- IDLE: core_found is ignored, no ack.

Simultaneous events:
- Grant and result arbitration run in parallel in the same cycle.
- new_work has priority over both: pending grant/result decisions for that edge are discarded, except stale-found acks.

Test Plan:
1. rst, new_work with nonce field 0x00000000; core_req=4'b0101 held one cycle, then core 0 drops -> cycle+1: grant core 0, base 0x00000000; cycle+2: grant core 2, base 0x00100000; busy=1.
2. core_req=4'b1111, each core re-requesting 2 cycles after its grant -> grant order 0,1,2,3,0,...; bases increment by 0x00100000.
3. new_work with start 0xFFF00000 -> first base 0xFFF00000, second 0x00000000. exhausted=1 with the 4096th grant (base 0xFFE00000); thereafter no grants with all req high.
4. Cores 1 and 3 raise found simultaneously with nonces 0x12345678 and 0x9ABCDEF0, found_ptr=0 -> new_result two consecutive cycles with 0x12345678 then 0x9ABCDEF0; ack[1] then ack[3].
5. new_work in RUN with core 2 found pending (0xDEADBEEF) -> core_abort one cycle; core 2 acked, new_result stays 0; exhausted cleared; next grant base = new start.
6. rst asserted mid-RUN while grant and new_result are active -> next cycle all outputs 0, state IDLE; no grants until new_work.
